isqrt_pipe: RTL and testbench

- Fully pipelined 32-bit unsigned integer square root; the responder side of the isqrt_x_vld/isqrt_x -> isqrt_y_vld/isqrt_y interface that the formula FSMs drive.
- It accepts one argument per clock and returns floor(sqrt(x)) after a fixed latency.
- It is instantiated once per formula top next to the formula FSM, which relies on its per-cycle throughput.
- There is no backpressure and no flow control beyond the valid bit.

---
 rtl/isqrt_pkg.sv | 29 ++
 rtl/isqrt_step.sv | 29 ++
 rtl/isqrt_pipe.sv | 67 ++++++
 tb/tb_isqrt_pipe.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isqrt_pkg.sv
// Shared widths, per-step pipeline record and a reference square root
// used by the bench model.
package isqrt_pkg;

  localparam int X_W   = 32;
  localparam int Y_W   = 16;
  localparam int REM_W = 18;

  typedef struct packed {
    logic [REM_W-1:0] rem;
    logic [Y_W-1:0]   root;
    logic [X_W-1:0]   xr;
  } isqrt_stage_t;

  // Greedy bit-by-bit search on the square: keep each root bit whose square still fits.
  function automatic logic [Y_W-1:0] isqrt_ref(input logic [X_W-1:0] x);
    logic [Y_W-1:0] r;
    logic [Y_W-1:0] c;
    logic [X_W-1:0] sq;
    r = '0;
    for (int b = Y_W - 1; b >= 0; b--) begin
      c  = r | (Y_W'(1) << b);
      sq = X_W'(c) * X_W'(c);
      if (sq <= x) r = c;
    end
    return r;
  endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root digit step: consumes the top two argument bits
// and resolves one root bit. Purely combinational.
module isqrt_step
  import isqrt_pkg::*;
(
  input  isqrt_stage_t i_cur,
  output isqrt_stage_t o_nxt
);

  logic [REM_W-1:0] w_trial;
  logic [REM_W:0]   w_diff;
  logic             w_unused;

  assign w_trial  = {i_cur.rem[Y_W-1:0], i_cur.xr[X_W-1:X_W-2]};
  // Extra top bit of the difference is the borrow.
  assign w_diff   = {1'b0, w_trial} - {1'b0, i_cur.root, 2'b01};
  assign w_unused = ^i_cur.rem[REM_W-1:Y_W];

  always_comb begin
    o_nxt.xr   = i_cur.xr << 2;
    o_nxt.rem  = w_trial;
    o_nxt.root = {i_cur.root[Y_W-2:0], 1'b0};
    if (!w_diff[REM_W]) begin
      o_nxt.rem  = w_diff[REM_W-1:0];
      o_nxt.root = {i_cur.root[Y_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/isqrt_pipe.sv
// Fully pipelined 32-bit integer square root, one argument per clock,
// result floor(sqrt(x)) exactly N_STAGES cycles later.
module isqrt_pipe
  import isqrt_pkg::*;
#(
  // Must divide 16 (2, 4, 8 or 16); each register stage resolves 16/N_STAGES root bits.
  parameter int N_STAGES = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           x_vld,
  input  logic [X_W-1:0] x,
  output logic           y_vld,
  output logic [Y_W-1:0] y
);

  localparam int STEPS = Y_W / N_STAGES;

  logic [N_STAGES-1:0] r_vld;
  logic                w_unused;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
    end else begin
      r_vld <= {r_vld[N_STAGES-2:0], x_vld};
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < N_STAGES; gi++) begin : g_stage
      isqrt_stage_t w_chain [STEPS+1];
      isqrt_stage_t r_data;
      logic         w_in_vld;

      if (gi == 0) begin : g_first
        assign w_chain[0] = {{REM_W{1'b0}}, {Y_W{1'b0}}, x};
        assign w_in_vld   = x_vld;
      end else begin : g_next
        assign w_chain[0] = g_stage[gi-1].r_data;
        assign w_in_vld   = r_vld[gi-1];
      end

      for (gj = 0; gj < STEPS; gj++) begin : g_step
        isqrt_step u_step (
          .i_cur (w_chain[gj]),
          .o_nxt (w_chain[gj+1])
        );
      end

      // Data only advances with a valid, so idle cycles leave y untouched.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_data <= '0;
        end else if (w_in_vld) begin
          r_data <= w_chain[STEPS];
        end
      end
    end
  endgenerate

  assign y_vld    = r_vld[N_STAGES-1];
  assign y        = g_stage[N_STAGES-1].r_data.root;
  assign w_unused = ^{g_stage[N_STAGES-1].r_data.rem, g_stage[N_STAGES-1].r_data.xr};

endmodule

// File: tb/tb_isqrt_pipe.sv
// Bench for isqrt_pipe: four builds (N_STAGES = 2, 4, 8, 16) share one stimulus
// stream; a scoreboard checks every result value and its exact latency.
module tb_isqrt_pipe;
  import isqrt_pkg::*;

  localparam int N_DUT = 4;
  localparam int MAIN  = 3;

  typedef struct {
    logic [15:0] y;
    int          due;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        x_vld = 1'b0;
  logic [31:0] x     = '0;
  logic        y_vld_a [N_DUT];
  logic [15:0] y_a     [N_DUT];

  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_mis = 0;
  exp_t sb_q [N_DUT][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  genvar gi;
  generate
    for (gi = 0; gi < N_DUT; gi++) begin : g_dut
      isqrt_pipe #(.N_STAGES(2 << gi)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .x_vld (x_vld),
        .x     (x),
        .y_vld (y_vld_a[gi]),
        .y     (y_a[gi])
      );
    end
  endgenerate

  task automatic issue(input logic v, input logic [31:0] val, input logic [15:0] ey);
    exp_t e;
    @(negedge clk);
    x_vld = v;
    x     = v ? val : $urandom();
    if (v && rst === 1'b1) begin
      for (int d = 0; d < N_DUT; d++) begin
        e.y   = ey;
        e.due = cyc + (2 << d);
        sb_q[d].push_back(e);
      end
    end
  endtask

  task automatic scoreboard_monitor();
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < N_DUT; d++) begin
        while (sb_q[d].size() > 0 && sb_q[d][0].due < cyc) begin
          e = sb_q[d].pop_front();
          n_cmp++; n_mis++;
          $display("FAIL sb_missing dut_n%0d: no y_vld by cycle %0d, required y=%0d at cycle %0d",
                   2 << d, cyc, e.y, e.due);
        end
        if (y_vld_a[d] === 1'b1) begin
          n_cmp++;
          if (sb_q[d].size() == 0) begin
            n_mis++;
            $display("FAIL sb_unexpected dut_n%0d: y_vld=1 y=%0d at cycle %0d, required y_vld=0",
                     2 << d, y_a[d], cyc);
          end else begin
            e = sb_q[d].pop_front();
            if (y_a[d] !== e.y || cyc != e.due) begin
              n_mis++;
              $display("FAIL sb_result dut_n%0d: y=%0d at cycle %0d, required y=%0d at cycle %0d",
                       2 << d, y_a[d], cyc, e.y, e.due);
            end
          end
        end else if (y_vld_a[d] !== 1'b0) begin
          n_cmp++; n_mis++;
          $display("FAIL sb_vld_x dut_n%0d: y_vld=%b, required 0 or 1", 2 << d, y_vld_a[d]);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < N_DUT; d++) begin
      n_cmp++;
      if (y_vld_a[d] !== 1'b0 || y_a[d] !== 16'h0) begin
        n_mis++;
        $display("FAIL reset_state dut_n%0d: y_vld=%b y=%h, required y_vld=0 y=0000",
                 2 << d, y_vld_a[d], y_a[d]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_edge_values();
    logic [31:0] vals [9] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd15, 32'd16,
                              32'hFFFF_FFFF, 32'hFFFE_0001};
    logic [15:0] exps [9] = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd2, 16'd3, 16'd4,
                              16'hFFFF, 16'hFFFF};
    for (int i = 0; i < 9; i++) begin
      issue(1'b1, vals[i], exps[i]);
      for (int k = 1; k < 20; k++) begin
        issue(1'b0, 32'h0, 16'h0);
        n_cmp++;
        if (y_vld_a[MAIN] !== (k == 16) || (k == 16 && y_a[MAIN] !== exps[i])) begin
          n_mis++;
          $display("FAIL edge_latency x=%h k=%0d: y_vld=%b y=%h, required y_vld=%0d y=%h",
                   vals[i], k, y_vld_a[MAIN], y_a[MAIN], k == 16, exps[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    int cnt = 0;
    int first = -1;
    int last = -1;
    for (int i = 0; i < 120; i++) begin
      if (i < 100) begin
        v = (i % 3 == 0) ? 32'($urandom_range(0, 5000)) : $urandom();
        issue(1'b1, v, isqrt_ref(v));
      end else begin
        issue(1'b0, 32'h0, 16'h0);
      end
      if (y_vld_a[MAIN] === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
    end
    n_cmp++;
    if (cnt != 100 || last - first != 99 || first != 16) begin
      n_mis++;
      $display("FAIL b2b_stream: %0d valids over span %0d starting at %0d, required 100 over 99 starting at 16",
               cnt, last - first, first);
    end
  endtask

  task automatic test_sparse();
    logic [6:0]  pat   = 7'b1001101;
    logic [31:0] vals [4] = '{32'd144, 32'd169, 32'd1_000_000, 32'd65535};
    logic [15:0] exps [4] = '{16'd12, 16'd13, 16'd1000, 16'd255};
    logic [63:0] in_pat  = '0;
    logic [63:0] out_pat = '0;
    int j = 0;
    for (int k = 0; k < 27; k++) begin
      if (k < 7 && pat[k]) begin
        issue(1'b1, vals[j], exps[j]);
        in_pat[k] = 1'b1;
        j++;
      end else begin
        issue(1'b0, 32'h0, 16'h0);
      end
      out_pat[k] = y_vld_a[MAIN];
    end
    n_cmp++;
    if (out_pat !== (in_pat << 16)) begin
      n_mis++;
      $display("FAIL sparse_pattern: y_vld pattern %h, required %h", out_pat, in_pat << 16);
    end
    for (int d = 0; d < N_DUT; d++) begin
      n_cmp++;
      if (y_vld_a[d] !== 1'b0 || y_a[d] !== 16'd255) begin
        n_mis++;
        $display("FAIL sparse_hold dut_n%0d: y_vld=%b y=%0d, required y_vld=0 y=255",
                 2 << d, y_vld_a[d], y_a[d]);
      end
    end
  endtask

  task automatic test_formula();
    int sum = 0;
    int cnt = 0;
    int first = -1;
    int last = -1;
    for (int k = 0; k < 23; k++) begin
      case (k)
        0: issue(1'b1, 32'd9, 16'd3);
        1: issue(1'b1, 32'd16, 16'd4);
        2: issue(1'b1, 32'd25, 16'd5);
        default: issue(1'b0, 32'h0, 16'h0);
      endcase
      if (y_vld_a[MAIN] === 1'b1) begin
        sum += int'(y_a[MAIN]);
        cnt++;
        if (first < 0) first = k;
        last = k;
      end
    end
    n_cmp++;
    if (sum != 12 || cnt != 3 || last - first != 2) begin
      n_mis++;
      $display("FAIL formula_sum: sum=%0d count=%0d span=%0d, required sum=12 count=3 span=2",
               sum, cnt, last - first);
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] v;
    int cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) begin
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int d = 0; d < N_DUT; d++) sb_q[d].delete();
        #1;
        for (int d = 0; d < N_DUT; d++) begin
          n_cmp++;
          if (y_vld_a[d] !== 1'b0 || y_a[d] !== 16'h0) begin
            n_mis++;
            $display("FAIL async_reset dut_n%0d: y_vld=%b y=%h, required y_vld=0 y=0000",
                     2 << d, y_vld_a[d], y_a[d]);
          end
        end
      end
      v = 32'd100 + 32'($urandom_range(0, 100000));
      issue(1'b1, v, isqrt_ref(v));
    end
    @(negedge clk);
    x_vld = 1'b0;
    rst   = 1'b1;
    issue(1'b1, 32'd49, 16'd7);
    for (int k = 0; k < 20; k++) begin
      issue(1'b0, 32'h0, 16'h0);
      if (y_vld_a[MAIN] === 1'b1) cnt++;
    end
    n_cmp++;
    if (cnt != 1 || y_a[MAIN] !== 16'd7) begin
      n_mis++;
      $display("FAIL reset_recover: %0d valids y=%0d, required 1 valid y=7", cnt, y_a[MAIN]);
    end
  endtask

  task automatic test_param_sweep();
    logic [31:0] v;
    logic [15:0] ey;
    logic [15:0] last_y = '0;
    int unsigned n;
    for (int i = 0; i < 60; i++) begin
      n = $urandom_range(1, 65535);
      case (i % 3)
        0: begin v = n * n;       ey = 16'(n);     end
        1: begin v = n * n - 1;   ey = 16'(n - 1); end
        default: begin v = $urandom(); ey = isqrt_ref(v); end
      endcase
      if ($urandom_range(0, 3) != 0) begin
        issue(1'b1, v, ey);
        last_y = ey;
      end else begin
        issue(1'b0, 32'h0, 16'h0);
      end
    end
    repeat (20) issue(1'b0, 32'h0, 16'h0);
    for (int d = 0; d < N_DUT; d++) begin
      n_cmp++;
      if (y_a[d] !== last_y || sb_q[d].size() != 0) begin
        n_mis++;
        $display("FAIL sweep_final dut_n%0d: y=%0d pending=%0d, required y=%0d pending=0",
                 2 << d, y_a[d], sb_q[d].size(), last_y);
      end
    end
  endtask

  initial begin
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_edge_values();
    test_back_to_back();
    test_sparse();
    test_formula();
    test_reset_midflight();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
